pio_cmd_sequencer: RTL and testbench

Sequences 32-bit command words that the HPS writes through the lightweight-bridge PIO ports into the FPGA-side graphics/processing engine. The block edge-detects the HPS start strobe, buffers the command in a small FIFO, and dispatches each word to the engine with a valid/ready handshake. It waits for the engine's completion or a timeout, then publishes a status word that the HPS reads back through a PIO input port. It sits between the soc_system PIO outputs/inputs and the engine command port.

---
 rtl/pio_cmd_sequencer.sv | 239 +++++++++++++++++++++++
 tb/tb_pio_cmd_sequencer.sv | 301 ++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/pio_cmd_sequencer.sv
// pio_cmd_sequencer
// Takes 32-bit command words written by the HPS through PIO ports, queues them
// in a small FIFO and hands them one at a time to the engine over a
// valid/ready handshake. After each handshake it waits for op_done or a
// timeout. A registered status word is published back to the HPS.
module pio_cmd_sequencer #(
    parameter int DEPTH   = 4,
    parameter int TIMEOUT = 1024
) (
    input  logic        clk,
    input  logic        reset,
    input  logic [31:0] cmd_data,
    input  logic        cmd_strobe,
    input  logic        status_clr,
    output logic [31:0] status,
    output logic [31:0] op_data,
    output logic        op_valid,
    input  logic        op_ready,
    input  logic        op_done
);

    localparam int              AW       = (DEPTH > 2) ? $clog2(DEPTH) : 1;
    localparam logic [3:0]      DEPTH_C  = 4'(DEPTH);
    localparam logic [15:0]     TMO_LAST = 16'(TIMEOUT - 1);

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_ISSUE = 2'd1,
        ST_WAIT  = 2'd2
    } state_t;

    // Input edge detection state
    logic        r_strobe_q;
    logic        r_strobe_arm;
    logic        r_clr_q;

    // FIFO storage and bookkeeping
    logic [31:0] r_mem [DEPTH];
    logic [AW-1:0] r_wr_ptr;
    logic [AW-1:0] r_rd_ptr;
    logic [3:0]  r_count;

    // Sequencer state
    state_t      r_state;
    logic [15:0] r_timer;
    logic        r_op_valid;
    logic [31:0] r_op_data;

    // Sticky flags and counters
    logic        r_overflow;
    logic        r_timeout;
    logic [15:0] r_done_count;
    logic [31:0] r_status;

    // Decoded events
    logic        w_strobe_rise;
    logic        w_clr_rise;
    logic        w_full;
    logic        w_pop;
    logic        w_push;
    logic        w_ovf_set;
    logic        w_done_inc;
    logic        w_tmo_set;
    logic        w_busy;

    // Wrap a FIFO pointer; DEPTH is a power of two so the natural overflow
    // of the pointer width gives modulo-DEPTH behaviour, except DEPTH=2 with
    // a 1-bit pointer which also wraps naturally.
    function automatic logic [AW-1:0] ptr_next(input logic [AW-1:0] p);
        ptr_next = p + AW'(1);
    endfunction

    // Combinational event decode shared by the FIFO, FSM and flag logic
    always_comb begin
        w_strobe_rise = 1'b0;
        w_clr_rise    = 1'b0;
        w_full        = 1'b0;
        w_pop         = 1'b0;
        w_push        = 1'b0;
        w_ovf_set     = 1'b0;
        w_done_inc    = 1'b0;
        w_tmo_set     = 1'b0;
        w_busy        = 1'b0;

        // A strobe that was high through reset release only counts once it
        // has been seen low at least once.
        w_strobe_rise = cmd_strobe & ~r_strobe_q & r_strobe_arm;
        w_clr_rise    = status_clr & ~r_clr_q;
        w_full        = (r_count == DEPTH_C);
        w_pop         = (r_state == ST_ISSUE) & op_ready;

        // A full FIFO still accepts a word when its head leaves this cycle.
        if (w_strobe_rise) begin
            if (!w_full || w_pop) begin
                w_push = 1'b1;
            end else begin
                w_ovf_set = 1'b1;
            end
        end else begin
            w_push    = 1'b0;
            w_ovf_set = 1'b0;
        end

        // Completion has priority over timeout in the same cycle.
        if (r_state == ST_WAIT) begin
            w_done_inc = op_done;
            w_tmo_set  = ~op_done & (r_timer == TMO_LAST);
        end else begin
            w_done_inc = 1'b0;
            w_tmo_set  = 1'b0;
        end

        w_busy = (r_state != ST_IDLE) | (r_count != 4'd0);
    end

    // Register the control inputs for edge detection
    always_ff @(posedge clk) begin
        if (reset) begin
            r_strobe_q   <= 1'b0;
            r_strobe_arm <= 1'b0;
            r_clr_q      <= 1'b0;
        end else begin
            r_strobe_q   <= cmd_strobe;
            r_strobe_arm <= r_strobe_arm | ~cmd_strobe;
            r_clr_q      <= status_clr;
        end
    end

    // FIFO storage write port
    always_ff @(posedge clk) begin
        if (reset) begin
            for (int i = 0; i < DEPTH; i++) begin
                r_mem[i] <= 32'h0000_0000;
            end
        end else if (w_push) begin
            r_mem[r_wr_ptr] <= cmd_data;
        end
    end

    // FIFO pointers and occupancy
    always_ff @(posedge clk) begin
        if (reset) begin
            r_wr_ptr <= '0;
            r_rd_ptr <= '0;
            r_count  <= 4'd0;
        end else begin
            if (w_push) begin
                r_wr_ptr <= ptr_next(r_wr_ptr);
            end
            if (w_pop) begin
                r_rd_ptr <= ptr_next(r_rd_ptr);
            end
            case ({w_push, w_pop})
                2'b10:   r_count <= r_count + 4'd1;
                2'b01:   r_count <= r_count - 4'd1;
                default: r_count <= r_count;
            endcase
        end
    end

    // Dispatch FSM: fetch head, hold it until accepted, then wait for completion
    always_ff @(posedge clk) begin
        if (reset) begin
            r_state    <= ST_IDLE;
            r_timer    <= 16'd0;
            r_op_valid <= 1'b0;
            r_op_data  <= 32'h0000_0000;
        end else begin
            case (r_state)
                ST_IDLE: begin
                    if (r_count != 4'd0) begin
                        r_state    <= ST_ISSUE;
                        r_op_valid <= 1'b1;
                        r_op_data  <= r_mem[r_rd_ptr];
                    end
                end
                ST_ISSUE: begin
                    if (op_ready) begin
                        r_state    <= ST_WAIT;
                        r_op_valid <= 1'b0;
                        r_timer    <= 16'd0;
                    end
                end
                ST_WAIT: begin
                    r_timer <= r_timer + 16'd1;
                    if (op_done || (r_timer == TMO_LAST)) begin
                        r_state <= ST_IDLE;
                    end
                end
                default: begin
                    r_state    <= ST_IDLE;
                    r_op_valid <= 1'b0;
                end
            endcase
        end
    end

    // Sticky flags and completion counter; a set event beats a clear
    always_ff @(posedge clk) begin
        if (reset) begin
            r_overflow   <= 1'b0;
            r_timeout    <= 1'b0;
            r_done_count <= 16'd0;
        end else begin
            if (w_ovf_set) begin
                r_overflow <= 1'b1;
            end else if (w_clr_rise) begin
                r_overflow <= 1'b0;
            end

            if (w_tmo_set) begin
                r_timeout <= 1'b1;
            end else if (w_clr_rise) begin
                r_timeout <= 1'b0;
            end

            if (w_done_inc) begin
                r_done_count <= r_done_count + 16'd1;
            end else if (w_clr_rise) begin
                r_done_count <= 16'd0;
            end
        end
    end

    // Status word snapshot for the HPS readback port
    always_ff @(posedge clk) begin
        if (reset) begin
            r_status <= 32'h0000_0000;
        end else begin
            r_status <= {w_busy, r_overflow, r_timeout, 1'b0, r_count,
                         8'h00, r_done_count};
        end
    end

    assign status   = r_status;
    assign op_data  = r_op_data;
    assign op_valid = r_op_valid;

endmodule

// File: tb/tb_pio_cmd_sequencer.sv
// Scoreboard bench for pio_cmd_sequencer (DEPTH=4, TIMEOUT=16).
// Stimulus pushes expected engine commands and expected status words into
// queues; a negedge monitor pops and compares them against the DUT.
module tb_pio_cmd_sequencer;

    logic        clk = 1'b0;
    logic        reset = 1'b1;
    logic [31:0] cmd_data = 32'h0;
    logic        cmd_strobe = 1'b0;
    logic        status_clr = 1'b0;
    logic [31:0] status;
    logic [31:0] op_data;
    logic        op_valid;
    logic        op_ready = 1'b0;
    logic        op_done = 1'b0;

    int          n_vec = 0;
    int          n_err = 0;
    logic [31:0] cmd_q [$];
    logic [31:0] st_q [$];
    logic        st_req = 1'b0;
    int          cmd_idx = 0;
    int          st_idx = 0;
    logic [31:0] mon_exp;

    pio_cmd_sequencer #(.DEPTH(4), .TIMEOUT(16)) dut (
        .clk        (clk),
        .reset      (reset),
        .cmd_data   (cmd_data),
        .cmd_strobe (cmd_strobe),
        .status_clr (status_clr),
        .status     (status),
        .op_data    (op_data),
        .op_valid   (op_valid),
        .op_ready   (op_ready),
        .op_done    (op_done)
    );

    always #5 clk = ~clk;

    // Monitor: handshakes and status sample requests, checked mid-cycle
    always @(negedge clk) begin
        if (!reset && op_valid && op_ready) begin
            n_vec++;
            if (cmd_q.size() == 0) begin
                n_err++;
                $display("FAIL cmd[%0d] unexpected: got %h required none", cmd_idx, op_data);
            end else begin
                mon_exp = cmd_q.pop_front();
                if (op_data !== mon_exp) begin
                    n_err++;
                    $display("FAIL cmd[%0d]: got %h required %h", cmd_idx, op_data, mon_exp);
                end
            end
            cmd_idx++;
        end
        if (st_req) begin
            n_vec++;
            if (st_q.size() == 0) begin
                n_err++;
                $display("FAIL status[%0d] no expectation: got %h", st_idx, status);
            end else begin
                mon_exp = st_q.pop_front();
                if (status !== mon_exp) begin
                    n_err++;
                    $display("FAIL status[%0d]: got %h required %h", st_idx, status, mon_exp);
                end
            end
            st_idx++;
        end
    end

    initial begin
        #500000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1);
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] req);
        n_vec++;
        if (act !== req) begin
            n_err++;
            $display("FAIL %s: got %h required %h", nm, act, req);
        end
    endtask

    task automatic strobe(input logic [31:0] d);
        cmd_data   = d;
        cmd_strobe = 1'b1;
        tick();
        cmd_strobe = 1'b0;
        tick();
    endtask

    task automatic clr_pulse();
        status_clr = 1'b1;
        tick();
        status_clr = 1'b0;
        tick();
    endtask

    task automatic expect_status(input logic [31:0] e);
        st_q.push_back(e);
        st_req = 1'b1;
        tick();
        st_req = 1'b0;
    endtask

    task automatic done_pulse();
        op_done = 1'b1;
        tick();
        op_done = 1'b0;
    endtask

    // Returns just after the handshake edge; a missing handshake is a failure
    task automatic wait_hs();
        bit hit;
        hit = 1'b0;
        for (int i = 0; i < 50; i++) begin
            if (op_valid && op_ready) begin
                tick();
                hit = 1'b1;
                break;
            end
            tick();
        end
        if (!hit) begin
            n_vec++;
            n_err++;
            $display("FAIL handshake_wait: got no handshake required one within 50 cycles");
        end
    endtask

    task automatic run_cmd();
        wait_hs();
        tick();
        tick();
        done_pulse();
    endtask

    initial begin
        // Reset state
        reset = 1'b1;
        repeat (3) tick();
        chk("rst_op_valid", {31'h0, op_valid}, 32'h0);
        chk("rst_op_data", op_data, 32'h0);
        expect_status(32'h0000_0000);
        reset = 1'b0;
        repeat (2) tick();

        // Single command, done 3 cycles after the handshake
        op_ready = 1'b1;
        cmd_q.push_back(32'hA5A5_0001);
        strobe(32'hA5A5_0001);
        chk("single_valid_on", {31'h0, op_valid}, 32'h1);
        wait_hs();
        chk("single_valid_off", {31'h0, op_valid}, 32'h0);
        tick();
        tick();
        done_pulse();
        tick();
        expect_status(32'h0000_0001);

        // Backpressure: valid and data stable for 10 cycles
        op_ready = 1'b0;
        cmd_q.push_back(32'h1234_5678);
        strobe(32'h1234_5678);
        for (int i = 0; i < 10; i++) begin
            chk("bp_valid", {31'h0, op_valid}, 32'h1);
            chk("bp_data", op_data, 32'h1234_5678);
            tick();
        end
        expect_status(32'h8100_0001);
        op_ready = 1'b1;
        wait_hs();
        tick();
        expect_status(32'h8000_0001);
        done_pulse();
        tick();
        tick();
        expect_status(32'h0000_0002);

        // Overflow: six words into a four-deep FIFO with the engine stalled
        clr_pulse();
        expect_status(32'h0000_0000);
        op_ready = 1'b0;
        for (int k = 1; k <= 6; k++) begin
            if (k <= 4) cmd_q.push_back(32'(k));
            strobe(32'(k));
        end
        expect_status(32'hC400_0000);
        op_ready = 1'b1;
        repeat (4) run_cmd();
        tick();
        tick();
        expect_status(32'h4000_0004);

        // Timeout: no op_done, flag at handshake+16, late done ignored
        clr_pulse();
        cmd_q.push_back(32'h0000_00C0);
        strobe(32'h0000_00C0);
        wait_hs();
        repeat (16) tick();
        expect_status(32'h8000_0000);
        expect_status(32'h2000_0000);
        done_pulse();
        tick();
        tick();
        expect_status(32'h2000_0000);

        // Full FIFO + rise + pop in one cycle: word accepted, count stays 4
        clr_pulse();
        op_ready = 1'b0;
        for (int k = 0; k < 4; k++) begin
            cmd_q.push_back(32'h11 + 32'(k));
            strobe(32'h11 + 32'(k));
        end
        cmd_q.push_back(32'h15);
        cmd_data   = 32'h15;
        cmd_strobe = 1'b1;
        op_ready   = 1'b1;
        tick();
        cmd_strobe = 1'b0;
        op_ready   = 1'b0;
        tick();
        expect_status(32'h8400_0000);
        done_pulse();
        op_ready = 1'b1;
        repeat (4) run_cmd();
        tick();
        tick();
        expect_status(32'h0000_0005);

        // op_done on the timeout cycle: counted, no timeout flag
        cmd_q.push_back(32'h0000_0050);
        strobe(32'h0000_0050);
        wait_hs();
        repeat (15) tick();
        done_pulse();
        tick();
        expect_status(32'h0000_0006);

        // status_clr in the same cycle as an overflow set
        op_ready = 1'b0;
        for (int k = 0; k < 4; k++) begin
            cmd_q.push_back(32'h21 + 32'(k));
            strobe(32'h21 + 32'(k));
        end
        cmd_data   = 32'h25;
        cmd_strobe = 1'b1;
        status_clr = 1'b1;
        tick();
        cmd_strobe = 1'b0;
        status_clr = 1'b0;
        tick();
        expect_status(32'hC400_0000);
        op_ready = 1'b1;
        repeat (4) run_cmd();
        tick();
        tick();
        expect_status(32'h4000_0004);

        // Reset mid-WAIT with two queued commands, strobe held across release
        cmd_q.push_back(32'h31);
        strobe(32'h31);
        wait_hs();
        op_ready = 1'b0;
        strobe(32'h32);
        strobe(32'h33);
        cmd_data   = 32'h99;
        cmd_strobe = 1'b1;
        reset      = 1'b1;
        repeat (3) tick();
        chk("rst2_op_valid", {31'h0, op_valid}, 32'h0);
        chk("rst2_op_data", op_data, 32'h0);
        expect_status(32'h0000_0000);
        reset = 1'b0;
        repeat (4) tick();
        expect_status(32'h0000_0000);
        chk("held_strobe_valid", {31'h0, op_valid}, 32'h0);
        cmd_strobe = 1'b0;
        tick();
        op_ready = 1'b1;
        cmd_q.push_back(32'h44);
        strobe(32'h44);
        run_cmd();
        tick();
        tick();
        expect_status(32'h0000_0001);

        chk("cmd_queue_drained", 32'(cmd_q.size()), 32'h0);
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
